uart_checker_core: RTL and testbench

Single-channel, runtime-configurable UART transmit/receive checker engine for the testbench UART checker wrapper. It replaces the fixed-generic checker: baud divisor, parity, stop bits and bit order become run-time inputs, and the data width and FIFO depth are parametrised. Error, overflow and level reporting are added. The wrapper instantiates one core per channel, and the scenario sequencer drives it through the wrapper interface.

---
 rtl/uart_checker_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 37 +++
 rtl/uart_checker_core.sv | 165 ++++++++++++++++
 tb/tb_uart_checker_core.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_checker_pkg.sv
// uart_checker_pkg: shared types, constants and parity helpers for the UART checker
package uart_checker_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, EVEN = 2'd1, ODD = 2'd2} parity_mode_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  localparam int C_MIN_BAUD_DIV = 4;
  function automatic logic parity_on(input logic [1:0] mode);
    return mode == EVEN || mode == ODD;
  endfunction
  // Unused upper data bits are zero, so they do not disturb the XOR.
  function automatic logic parity_calc(input logic [8:0] data, input logic [1:0] mode);
    return mode == ODD ? ~^data : mode == EVEN ? ^data : 1'b0;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO with full/empty/level, no push-through
module uart_sync_fifo #(
  parameter int G_WIDTH = 8,
  parameter int G_ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [G_WIDTH-1:0]      wr_data,
  output logic                    full,
  input  logic                    rd_en,
  output logic [G_WIDTH-1:0]      rd_data,
  output logic                    empty,
  output logic [G_ADDR_WIDTH:0]   level
);
  logic [G_WIDTH-1:0] mem [2**G_ADDR_WIDTH];
  logic [G_ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic push, pop;
  always_comb begin
    level = wr_ptr - rd_ptr;
    full = level[G_ADDR_WIDTH];
    empty = level == '0;
    push = wr_en && !full;
    pop = rd_en && !empty;
    rd_data = empty ? '0 : mem[rd_ptr[G_ADDR_WIDTH-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + (G_ADDR_WIDTH+1)'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + (G_ADDR_WIDTH+1)'(1) : rd_ptr;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[G_ADDR_WIDTH-1:0]] <= wr_data;
endmodule

// File: rtl/uart_checker_core.sv
// uart_checker_core: runtime-configurable UART TX/RX checker with FIFOs and sticky error flags
module uart_checker_core
  import uart_checker_pkg::*;
#(
  parameter int G_DATA_WIDTH = 8,
  parameter int G_BUFFER_ADDR_WIDTH = 4,
  parameter int G_DIV_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [G_DIV_WIDTH-1:0]         i_baud_div,
  input  logic [1:0]                     i_parity_mode,
  input  logic                           i_stop_bits,
  input  logic                           i_first_bit,
  input  logic                           i_tx_valid,
  input  logic [G_DATA_WIDTH-1:0]        i_tx_data,
  output logic                           o_tx_ready,
  output logic                           o_tx,
  output logic                           o_tx_busy,
  input  logic                           i_rx,
  output logic                           o_rx_valid,
  output logic [G_DATA_WIDTH-1:0]        o_rx_data,
  input  logic                           i_rx_ready,
  output logic [G_BUFFER_ADDR_WIDTH:0]   o_rx_level,
  output logic                           o_parity_err,
  output logic                           o_frame_err,
  output logic                           o_overflow,
  input  logic                           i_clr_err
);
  localparam int DW = G_DIV_WIDTH;
  localparam int IW = $clog2(G_DATA_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(G_DATA_WIDTH - 1);
  logic [DW-1:0] div_eff;
  assign div_eff = i_baud_div < DW'(C_MIN_BAUD_DIV) ? DW'(C_MIN_BAUD_DIV) : i_baud_div;
  tx_state_t tx_state, tx_next;
  logic tx_full, tx_empty, tx_pop, tx_tick, tx_last_stop, tx_bit, tx_tail, tx_two, tx_msb, tx_stop2nd;
  logic [G_DATA_WIDTH-1:0] tx_head, tx_word;
  logic [G_BUFFER_ADDR_WIDTH:0] tx_level;
  logic [DW-1:0] tx_div, tx_cnt;
  logic [1:0] tx_par;
  logic [IW-1:0] tx_idx, tx_bit_idx;
  uart_sync_fifo #(.G_WIDTH(G_DATA_WIDTH), .G_ADDR_WIDTH(G_BUFFER_ADDR_WIDTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(i_tx_valid), .wr_data(i_tx_data), .full(tx_full),
    .rd_en(tx_pop), .rd_data(tx_head), .empty(tx_empty), .level(tx_level)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tx_state <= TX_IDLE;
    else tx_state <= tx_next;
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (!tx_empty) tx_next = TX_START;
      TX_START:  if (tx_tick) tx_next = TX_DATA;
      TX_DATA:   if (tx_tick && tx_idx == LAST_IDX) tx_next = parity_on(tx_par) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_tick) tx_next = TX_STOP;
      TX_STOP:   if (tx_last_stop) tx_next = tx_empty ? TX_IDLE : TX_START;
      default:   tx_next = TX_IDLE;
    endcase
  end
  // The next word is fetched on the final stop tick so back-to-back frames have no idle gap.
  always_comb begin
    tx_tick = tx_cnt == tx_div - DW'(1);
    tx_last_stop = tx_tick && (!tx_two || tx_stop2nd);
    tx_pop = !tx_empty && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_last_stop));
    tx_bit_idx = tx_msb ? LAST_IDX - tx_idx : tx_idx;
    tx_bit = tx_state == TX_START ? 1'b0 :
             tx_state == TX_DATA ? tx_word[tx_bit_idx] :
             tx_state == TX_PARITY ? parity_calc(9'(tx_word), tx_par) : 1'b1;
    o_tx_busy = tx_level != '0 || tx_state != TX_IDLE || tx_tail;
    o_tx_ready = !tx_full;
  end
  // The serial line is registered, so tx_tail keeps busy asserted until the stop bit leaves the pin.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_stop2nd <= 1'b0;
      tx_word <= '0;
      tx_div <= DW'(C_MIN_BAUD_DIV);
      tx_par <= '0;
      tx_two <= 1'b0;
      tx_msb <= 1'b0;
      o_tx <= 1'b1;
      tx_tail <= 1'b0;
    end else begin
      tx_cnt <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + DW'(1);
      tx_idx <= tx_state != TX_DATA ? '0 : tx_tick ? tx_idx + IW'(1) : tx_idx;
      tx_stop2nd <= tx_state != TX_STOP ? 1'b0 : tx_tick ? 1'b1 : tx_stop2nd;
      if (tx_pop) begin
        tx_word <= tx_head;
        tx_div <= div_eff;
        tx_par <= i_parity_mode;
        tx_two <= i_stop_bits;
        tx_msb <= i_first_bit;
      end
      o_tx <= tx_bit;
      tx_tail <= tx_state != TX_IDLE;
    end
  rx_state_t rx_state, rx_next;
  logic rx_s1, rx_s2, rx_prev, rx_fall, rx_sample, rx_push, rx_full, rx_empty, rx_msb;
  logic par_set, frame_set, ovf_set;
  logic [G_DATA_WIDTH-1:0] rx_word;
  logic [DW-1:0] rx_div, rx_cnt;
  logic [1:0] rx_par;
  logic [IW-1:0] rx_idx, rx_bit_idx;
  uart_sync_fifo #(.G_WIDTH(G_DATA_WIDTH), .G_ADDR_WIDTH(G_BUFFER_ADDR_WIDTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(rx_push), .wr_data(rx_word), .full(rx_full),
    .rd_en(i_rx_ready), .rd_data(o_rx_data), .empty(rx_empty), .level(o_rx_level)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rx_state <= RX_IDLE;
    else rx_state <= rx_next;
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_fall) rx_next = RX_START;
      RX_START:  if (rx_sample) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_sample && rx_idx == LAST_IDX) rx_next = parity_on(rx_par) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_sample) rx_next = RX_STOP;
      RX_STOP:   if (rx_sample) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end
  // The start bit is sampled at half a bit; every later sample is a full bit after the previous one.
  always_comb begin
    rx_fall = rx_prev && !rx_s2;
    rx_sample = rx_state == RX_START ? rx_cnt == (rx_div >> 1) - DW'(1) : rx_cnt == rx_div - DW'(1);
    rx_bit_idx = rx_msb ? LAST_IDX - rx_idx : rx_idx;
    rx_push = rx_state == RX_STOP && rx_sample;
    par_set = rx_state == RX_PARITY && rx_sample && rx_s2 != parity_calc(9'(rx_word), rx_par);
    frame_set = rx_push && !rx_s2;
    ovf_set = rx_push && rx_full;
    o_rx_valid = !rx_empty;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_prev <= 1'b1;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_word <= '0;
      rx_div <= DW'(C_MIN_BAUD_DIV);
      rx_par <= '0;
      rx_msb <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      rx_cnt <= (rx_state == RX_IDLE || rx_sample) ? '0 : rx_cnt + DW'(1);
      rx_idx <= rx_state != RX_DATA ? '0 : rx_sample ? rx_idx + IW'(1) : rx_idx;
      if (rx_state == RX_DATA && rx_sample) rx_word[rx_bit_idx] <= rx_s2;
      if (rx_state == RX_IDLE && rx_fall) begin
        rx_div <= div_eff;
        rx_par <= i_parity_mode;
        rx_msb <= i_first_bit;
      end
      o_parity_err <= par_set | (o_parity_err & ~i_clr_err);
      o_frame_err <= frame_set | (o_frame_err & ~i_clr_err);
      o_overflow <= ovf_set | (o_overflow & ~i_clr_err);
    end
endmodule

// File: tb/tb_uart_checker_core.sv
// tb_uart_checker_core: directed self-checking bench for the UART checker core
module tb_uart_checker_core;
  localparam int W = 8, AW = 2, DW = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] baud_div = 16'd4;
  logic [1:0] parity_mode = 2'd0;
  logic stop_bits = 1'b0, first_bit = 1'b0, tx_valid = 1'b0, rx_ready = 1'b0, clr_err = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic tx_ready, tx, busy, rx_in, rx_valid, perr, ferr, ovf;
  logic [W-1:0] rx_data;
  logic [AW:0] rx_level;
  logic loop = 1'b0, rx_drv = 1'b1;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  assign rx_in = loop ? tx : rx_drv;
  uart_checker_core #(.G_DATA_WIDTH(W), .G_BUFFER_ADDR_WIDTH(AW), .G_DIV_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .i_baud_div(baud_div), .i_parity_mode(parity_mode),
    .i_stop_bits(stop_bits), .i_first_bit(first_bit), .i_tx_valid(tx_valid), .i_tx_data(tx_data),
    .o_tx_ready(tx_ready), .o_tx(tx), .o_tx_busy(busy), .i_rx(rx_in), .o_rx_valid(rx_valid),
    .o_rx_data(rx_data), .i_rx_ready(rx_ready), .o_rx_level(rx_level), .o_parity_err(perr),
    .o_frame_err(ferr), .o_overflow(ovf), .i_clr_err(clr_err)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [W-1:0] d);
    int i = 0;
    while (!tx_ready && i < 100) begin
      step(1);
      i++;
    end
    check("push_ready", 16'(tx_ready), 16'd1);
    tx_valid = 1'b1;
    tx_data = d;
    step(1);
    tx_valid = 1'b0;
  endtask
  task automatic pop(input string tag, input logic [W-1:0] exp);
    check({tag, "_valid"}, 16'(rx_valid), 16'd1);
    check({tag, "_data"}, 16'(rx_data), 16'(exp));
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask
  // bits[k] is the k-th serial bit on the line: start, data, stop.
  task automatic tx_watch(input string tag, input logic [W-1:0] d, input logic [9:0] bits);
    push(d);
    check({tag, "_busy_start"}, 16'(busy), 16'd1);
    step(1);
    check({tag, "_latency"}, 16'(tx), 16'd1);
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 4; j++) begin
        step(1);
        check($sformatf("%s_bit%0d_clk%0d", tag, k, j), 16'(tx), 16'(bits[k]));
      end
    check({tag, "_busy_stop"}, 16'(busy), 16'd1);
    step(1);
    check({tag, "_busy_end"}, 16'(busy), 16'd0);
    check({tag, "_idle"}, 16'(tx), 16'd1);
  endtask
  task automatic rx_bit(input logic b);
    rx_drv = b;
    step(int'(baud_div));
  endtask
  task automatic rx_frame(input logic [7:0] d, input logic has_par, input logic par, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
    if (has_par) rx_bit(par);
    rx_bit(stop);
    rx_bit(1'b1);
    rx_bit(1'b1);
  endtask
  initial begin
    logic low_seen;
    step(3);
    check("rst_tx", 16'(tx), 16'd1);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_ready", 16'(tx_ready), 16'd1);
    check("rst_rx_valid", 16'(rx_valid), 16'd0);
    check("rst_rx_data", 16'(rx_data), 16'd0);
    check("rst_rx_level", 16'(rx_level), 16'd0);
    check("rst_perr", 16'(perr), 16'd0);
    check("rst_ferr", 16'(ferr), 16'd0);
    check("rst_ovf", 16'(ovf), 16'd0);
    rst_n = 1'b1;
    step(2);
    tx_watch("t1_a5_lsb", 8'hA5, 10'b1101001010);
    first_bit = 1'b1;
    tx_watch("t1_c1_msb", 8'hC1, 10'b1100000110);
    first_bit = 1'b0;
    step(2);
    loop = 1'b1;
    parity_mode = 2'd1;
    stop_bits = 1'b1;
    push(8'h07);
    push(8'h00);
    push(8'hFF);
    for (int c = 1; c <= 170; c++) begin
      step(1);
      if (c == 37) check("t2_par0", 16'(tx), 16'd1);
      if (c == 85) check("t2_par1", 16'(tx), 16'd0);
      if (c == 133) check("t2_par2", 16'(tx), 16'd0);
    end
    check("t2_level", 16'(rx_level), 16'd3);
    pop("t2_w0", 8'h07);
    pop("t2_w1", 8'h00);
    pop("t2_w2", 8'hFF);
    check("t2_perr", 16'(perr), 16'd0);
    check("t2_ferr", 16'(ferr), 16'd0);
    check("t2_ovf", 16'(ovf), 16'd0);
    loop = 1'b0;
    stop_bits = 1'b0;
    parity_mode = 2'd0;
    baud_div = 16'd8;
    step(4);
    rx_drv = 1'b0;
    step(2);
    rx_drv = 1'b1;
    step(30);
    check("t3_level", 16'(rx_level), 16'd0);
    check("t3_ferr", 16'(ferr), 16'd0);
    check("t3_perr", 16'(perr), 16'd0);
    rx_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("t4_level_a", 16'(rx_level), 16'd1);
    check("t4_data_a", 16'(rx_data), 16'h3C);
    check("t4_ferr_a", 16'(ferr), 16'd1);
    check("t4_perr_a", 16'(perr), 16'd0);
    parity_mode = 2'd2;
    rx_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    check("t4_level_b", 16'(rx_level), 16'd2);
    check("t4_perr_b", 16'(perr), 16'd1);
    check("t4_ferr_b", 16'(ferr), 16'd1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    check("t4_perr_clr", 16'(perr), 16'd0);
    check("t4_ferr_clr", 16'(ferr), 16'd0);
    pop("t4_w0", 8'h3C);
    pop("t4_w1", 8'h3C);
    baud_div = 16'd4;
    parity_mode = 2'd0;
    loop = 1'b1;
    for (int i = 1; i <= 5; i++) push(8'(i));
    step(260);
    check("t5_level", 16'(rx_level), 16'd4);
    check("t5_ovf", 16'(ovf), 16'd1);
    check("t5_ferr", 16'(ferr), 16'd0);
    check("t5_perr", 16'(perr), 16'd0);
    for (int i = 1; i <= 4; i++) pop($sformatf("t5_w%0d", i), 8'(i));
    check("t5_empty", 16'(rx_valid), 16'd0);
    loop = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h11 + i));
    step(10);
    check("t6_busy_pre", 16'(busy), 16'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx", 16'(tx), 16'd1);
    check("t6_rst_busy", 16'(busy), 16'd0);
    check("t6_rst_ready", 16'(tx_ready), 16'd1);
    check("t6_rst_ovf", 16'(ovf), 16'd0);
    step(2);
    rst_n = 1'b1;
    low_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step(1);
      low_seen |= !tx;
    end
    check("t6_no_frame", 16'(low_seen), 16'd0);
    check("t6_busy", 16'(busy), 16'd0);
    check("t6_ready", 16'(tx_ready), 16'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
